// File: rtl/cpu16_bus_pkg.sv
// Shared CPU16 bus types: arbiter FSM states, grant owner codes
// and the default RAM read-latency setting.
package cpu16_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  localparam int DEFAULT_RAM_WAIT = 1;

endpackage

// File: rtl/cpu16_mem_arbiter.sv
// Single-port RAM arbiter between the CPU16 core and a DMA/video
// fetcher: fixed DMA priority with a bounded CPU stall count.
module cpu16_mem_arbiter
  import cpu16_bus_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RAM_WAIT  = DEFAULT_RAM_WAIT,
  parameter int MAX_STALL = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              owner
);

  localparam logic [2:0] WAIT_LAST = 3'(RAM_WAIT - 1);
  localparam logic [3:0] STALL_MAX = 4'(MAX_STALL);

  arb_state_t        state_q, state_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic [3:0]        stall_cnt_q, stall_cnt_d;
  logic              owner_q, owner_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic              dma_win, cpu_win, go_done;

  always_comb begin
    dma_win = dma_req && !(cpu_req && stall_cnt_q == STALL_MAX);
    cpu_win = cpu_req && !dma_win;
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    owner_d     = owner_q;
    is_wr_d     = is_wr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = ram_we_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    go_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ram_we_d = 1'b0;
        if (!cpu_req || cpu_win) begin
          stall_cnt_d = '0;
        end else if (stall_cnt_q < STALL_MAX) begin
          stall_cnt_d = stall_cnt_q + 4'd1;
        end
        if (dma_win || cpu_win) begin
          owner_d     = dma_win ? OWNER_DMA : OWNER_CPU;
          is_wr_d     = dma_win ? dma_we : cpu_we;
          ram_addr_d  = dma_win ? dma_addr : cpu_addr;
          ram_wdata_d = dma_win ? dma_wdata : cpu_wdata;
          ram_we_d    = dma_win ? dma_we : cpu_we;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        ram_we_d   = 1'b0;
        wait_cnt_d = '0;
        if (RAM_WAIT == 0) begin
          go_done = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          go_done = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Capture on entry to DONE so rdata is valid alongside ack
    if (go_done) begin
      state_d = DONE;
      if (owner_q == OWNER_DMA) begin
        dma_ack_d = 1'b1;
        if (!is_wr_q) dma_rdata_d = ram_rdata;
      end else begin
        cpu_ack_d = 1'b1;
        if (!is_wr_q) cpu_rdata_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      owner_q     <= OWNER_CPU;
      is_wr_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      owner_q     <= owner_d;
      is_wr_q     <= is_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ack   = dma_ack_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign owner     = owner_q;

  // Requester must hold req while its transfer is in flight
  a_cpu_hold: assert property (@(posedge clk) disable iff (!reset)
    ((state_q == ACCESS || state_q == WAIT) && owner_q == OWNER_CPU)
    |-> cpu_req);
  a_dma_hold: assert property (@(posedge clk) disable iff (!reset)
    ((state_q == ACCESS || state_q == WAIT) && owner_q == OWNER_DMA)
    |-> dma_req);

endmodule

// File: tb/tb_cpu16_mem_arbiter.sv
// Directed bench for cpu16_mem_arbiter: vector table of CPU
// transfers plus arbitration, latency, reset and hold sequences.
module tb_cpu16_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        c_req = 0, c_we = 0;
  logic [15:0] c_addr = 0, c_wdata = 0;
  logic [15:0] c_rdata;
  logic        c_ack;
  logic        d_req = 0, d_we = 0;
  logic [15:0] d_addr = 0, d_wdata = 0;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we, owner;

  logic        z_req = 0, t_req = 0;
  logic [15:0] z_rdata, t_rdata, z_drd, t_drd;
  logic        z_ack, t_ack, z_dack, t_dack;
  logic [15:0] z_ra, z_rw, t_ra, t_rw;
  logic        z_we, t_we, z_own, t_own;

  logic [15:0] mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  cpu16_mem_arbiter #(.RAM_WAIT(1), .MAX_STALL(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr),
    .cpu_wdata(c_wdata), .cpu_rdata(c_rdata), .cpu_ack(c_ack),
    .dma_req(d_req), .dma_we(d_we), .dma_addr(d_addr),
    .dma_wdata(d_wdata), .dma_rdata(d_rdata), .dma_ack(d_ack),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .owner(owner)
  );

  cpu16_mem_arbiter #(.RAM_WAIT(0)) dut_w0 (
    .clk(clk), .reset(reset),
    .cpu_req(z_req), .cpu_we(1'b0), .cpu_addr(16'h0042),
    .cpu_wdata(16'h0), .cpu_rdata(z_rdata), .cpu_ack(z_ack),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0),
    .dma_wdata(16'h0), .dma_rdata(z_drd), .dma_ack(z_dack),
    .ram_addr(z_ra), .ram_wdata(z_rw), .ram_we(z_we),
    .ram_rdata(16'h0A0A), .owner(z_own)
  );

  cpu16_mem_arbiter #(.RAM_WAIT(3)) dut_w3 (
    .clk(clk), .reset(reset),
    .cpu_req(t_req), .cpu_we(1'b0), .cpu_addr(16'h0043),
    .cpu_wdata(16'h0), .cpu_rdata(t_rdata), .cpu_ack(t_ack),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0),
    .dma_wdata(16'h0), .dma_rdata(t_drd), .dma_ack(t_dack),
    .ram_addr(t_ra), .ram_wdata(t_rw), .ram_we(t_we),
    .ram_rdata(16'h3C3C), .owner(t_own)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cpu_xfer(input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input bit chg,
                          input logic [15:0] addr2, output int lat,
                          output logic [15:0] a1,
                          output logic [15:0] a_end, output int wec,
                          output logic [15:0] wd,
                          output logic [15:0] rd);
    c_req = 1; c_we = we; c_addr = addr; c_wdata = wdata;
    lat = -1; wec = 0; wd = 0; a1 = 0; a_end = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) a1 = ram_addr;
      if (ram_we) begin wec++; wd = ram_wdata; end
      if (chg && k == 2) c_addr = addr2;
      if (c_ack) begin lat = k; a_end = ram_addr; break; end
    end
    rd = c_rdata;
    c_req = 0; c_we = 0;
    @(posedge clk); #1;
  endtask

  vec_t vecs [13];

  initial begin
    int lat, wec, n, both;
    logic [15:0] a1, a_end, wd, rd, dr;
    logic [7:0] got;

    vecs[0]  = '{1'b1, 16'h4000, 16'h1234, 16'h0};
    vecs[1]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0};
    vecs[2]  = '{1'b1, 16'h1000, 16'h1111, 16'h0};
    vecs[3]  = '{1'b1, 16'h2000, 16'h2222, 16'h0};
    vecs[4]  = '{1'b1, 16'h0100, 16'h0111, 16'h0};
    vecs[5]  = '{1'b1, 16'h0200, 16'h0222, 16'h0};
    vecs[6]  = '{1'b1, 16'hFFFF, 16'h8001, 16'h0};
    vecs[7]  = '{1'b0, 16'h4000, 16'h0, 16'h1234};
    vecs[8]  = '{1'b0, 16'h0010, 16'h0, 16'hBEEF};
    vecs[9]  = '{1'b0, 16'hFFFF, 16'h0, 16'h8001};
    vecs[10] = '{1'b1, 16'h0010, 16'h0000, 16'h0};
    vecs[11] = '{1'b0, 16'h0010, 16'h0, 16'h0000};
    vecs[12] = '{1'b0, 16'h1000, 16'h0, 16'h1111};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_ack", {31'b0, c_ack}, 0);
    chk("rst_dma_ack", {31'b0, d_ack}, 0);
    chk("rst_cpu_rdata", {16'b0, c_rdata}, 0);
    chk("rst_dma_rdata", {16'b0, d_rdata}, 0);
    chk("rst_ram_addr", {16'b0, ram_addr}, 0);
    chk("rst_ram_wdata", {16'b0, ram_wdata}, 0);
    chk("rst_ram_we", {31'b0, ram_we}, 0);
    chk("rst_owner", {31'b0, owner}, 0);
    @(posedge clk); #1;
    reset = 1;

    // table-driven CPU transfers
    for (int i = 0; i < 13; i++) begin
      cpu_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, 16'h0,
               lat, a1, a_end, wec, wd, rd);
      chk($sformatf("v%0d_lat", i), lat, 3);
      chk($sformatf("v%0d_addr_c1", i), {16'b0, a1},
          {16'b0, vecs[i].addr});
      if (vecs[i].we) begin
        chk($sformatf("v%0d_we_cycles", i), wec, 1);
        chk($sformatf("v%0d_wdata", i), {16'b0, wd},
            {16'b0, vecs[i].wdata});
      end else begin
        chk($sformatf("v%0d_we_cycles", i), wec, 0);
        chk($sformatf("v%0d_rdata", i), {16'b0, rd},
            {16'b0, vecs[i].exp_rd});
      end
    end

    // both ports requesting continuously
    c_req = 1; c_we = 0; c_addr = 16'h1000;
    d_req = 1; d_we = 0; d_addr = 16'h2000;
    n = 0; both = 0; got = '0; dr = '0;
    for (int k = 0; k < 80 && n < 8; k++) begin
      @(posedge clk); #1;
      if (c_ack && d_ack) both++;
      if (d_ack) begin
        got[n] = 1'b1; dr = d_rdata; n++;
      end else if (c_ack) begin
        got[n] = 1'b0; n++;
      end
    end
    c_req = 0; d_req = 0;
    @(posedge clk); #1;
    chk("grant_count", n, 8);
    chk("grant_order", {24'b0, got}, 32'h77);
    chk("dual_ack", both, 0);
    chk("dma_rdata", {16'b0, dr}, 32'h2222);
    chk("cpu_rdata_arb", {16'b0, c_rdata}, 32'h1111);

    // RAM_WAIT=0 and RAM_WAIT=3 latency
    z_req = 1; t_req = 1;
    begin
      int lz, lt;
      lz = -1; lt = -1;
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk); #1;
        if (z_ack && lz < 0) begin lz = k; z_req = 0; end
        if (t_ack && lt < 0) begin lt = k; t_req = 0; end
      end
      z_req = 0; t_req = 0;
      chk("w0_lat", lz, 2);
      chk("w3_lat", lt, 5);
      chk("w0_rdata", {16'b0, z_rdata}, 32'h0A0A);
      chk("w3_rdata", {16'b0, t_rdata}, 32'h3C3C);
    end

    // reset during WAIT of a DMA write
    d_req = 1; d_we = 1; d_addr = 16'h0300; d_wdata = 16'h7777;
    @(posedge clk); #1;
    chk("dw_access_we", {31'b0, ram_we}, 1);
    chk("dw_owner", {31'b0, owner}, 1);
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("rst_mid_we", {31'b0, ram_we}, 0);
    chk("rst_mid_dack", {31'b0, d_ack}, 0);
    chk("rst_mid_cack", {31'b0, c_ack}, 0);
    chk("rst_mid_owner", {31'b0, owner}, 0);
    @(posedge clk); #1;
    chk("rst_hold_dack", {31'b0, d_ack}, 0);
    reset = 1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("reissue_addr", {16'b0, ram_addr}, 32'h0300);
      if (d_ack) begin lat = k; break; end
    end
    d_req = 0; d_we = 0;
    @(posedge clk); #1;
    chk("reissue_lat", lat, 3);
    cpu_xfer(1'b0, 16'h0300, 16'h0, 1'b0, 16'h0,
             lat, a1, a_end, wec, wd, rd);
    chk("reissue_read", {16'b0, rd}, 32'h7777);

    // CPU address changed mid-transfer
    cpu_xfer(1'b0, 16'h0100, 16'h0, 1'b1, 16'h0200,
             lat, a1, a_end, wec, wd, rd);
    chk("hold_lat", lat, 3);
    chk("hold_addr", {16'b0, a_end}, 32'h0100);
    chk("hold_rdata", {16'b0, rd}, 32'h0111);

    // cpu_rdata holds after ack
    repeat (3) @(posedge clk);
    #1;
    chk("rdata_held", {16'b0, c_rdata}, 32'h0111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
